// File: rtl/uart_mmio_pkg.sv
// Shared register map, status bit positions and the UART state type
// used by both the transmit and receive engines of uart_mmio.
package uart_mmio_pkg;

  localparam logic [3:0] OFS_RXDATA = 4'h0;
  localparam logic [3:0] OFS_TXDATA = 4'h4;
  localparam logic [3:0] OFS_STATUS = 4'hC;

  localparam int unsigned ST_RX_NONEMPTY = 0;
  localparam int unsigned ST_TX_FULL     = 1;
  localparam int unsigned ST_TX_IDLE     = 2;
  localparam int unsigned ST_RX_OVF      = 3;
  localparam int unsigned ST_FRAME_ERR   = 4;
  localparam int unsigned ST_TX_OVF      = 5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

endpackage

// File: rtl/uart_mmio_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push and pop together are
// legal when full or empty, and a rejected push is flagged on o_drop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_rdata   = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_rst) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART: bus decode, TX/RX FIFOs, TX serialiser and
// RX deserialiser with sticky error flags cleared by a STATUS read.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  write_enable,
  input  logic        read_enable,
  output logic [31:0] dout,
  output logic        txd,
  input  logic        rxd
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BAUD_ONE  = {{(BW-1){1'b0}}, 1'b1};

  logic        w_hit;
  logic [3:0]  w_ofs;
  logic        w_wr;
  logic        w_rd;
  logic        w_tx_push;
  logic        w_tx_pop;
  logic        w_rx_push;
  logic        w_rx_pop;
  logic        w_st_clr;
  logic        w_tx_empty;
  logic        w_tx_full;
  logic        w_tx_drop;
  logic [7:0]  w_tx_rdata;
  logic        w_rx_empty;
  logic        w_rx_full;
  logic        w_rx_drop;
  logic [7:0]  w_rx_rdata;
  logic        w_rx_stop_smp;
  logic        w_rx_ferr;
  logic        w_tx_idle;
  logic [31:0] w_status;
  logic        w_unused;

  uart_state_t r_tx_state;
  logic [BW-1:0] r_tx_baud;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_txd;

  uart_state_t r_rx_state;
  logic [BW-1:0] r_rx_baud;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_shift;
  logic        r_rx_s1;
  logic        r_rx_s2;

  logic        r_tx_ovf;
  logic        r_rx_ovf;
  logic        r_frame_err;
  logic [31:0] r_dout;

  assign w_unused = &{1'b0, din[31:8], w_rx_full};

  // Register decode; a write in the same cycle as a read suppresses the read.
  assign w_hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign w_ofs     = addr[3:0];
  assign w_wr      = |write_enable;
  assign w_rd      = read_enable && !w_wr;
  assign w_tx_push = w_hit && w_wr && (w_ofs == OFS_TXDATA);
  assign w_rx_pop  = w_hit && w_rd && (w_ofs == OFS_RXDATA);
  assign w_st_clr  = w_hit && w_rd && (w_ofs == OFS_STATUS);

  assign w_tx_pop      = (r_tx_state == IDLE) && !w_tx_empty;
  assign w_tx_idle     = (r_tx_state == IDLE) && w_tx_empty;
  assign w_rx_stop_smp = (r_rx_state == STOP) && (r_rx_baud == BAUD_LAST);
  assign w_rx_push     = w_rx_stop_smp && r_rx_s2;
  assign w_rx_ferr     = w_rx_stop_smp && !r_rx_s2;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_tx_push),
    .i_wdata (din[7:0]),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_empty (w_tx_empty),
    .o_full  (w_tx_full),
    .o_drop  (w_tx_drop)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_rx_push),
    .i_wdata (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_rdata (w_rx_rdata),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full),
    .o_drop  (w_rx_drop)
  );

  always_comb begin
    w_status                 = '0;
    w_status[ST_RX_NONEMPTY] = !w_rx_empty;
    w_status[ST_TX_FULL]     = w_tx_full;
    w_status[ST_TX_IDLE]     = w_tx_idle;
    w_status[ST_RX_OVF]      = r_rx_ovf;
    w_status[ST_FRAME_ERR]   = r_frame_err;
    w_status[ST_TX_OVF]      = r_tx_ovf;
  end

  // Sticky flags: a set event in the clearing cycle keeps the flag high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_ovf    <= 1'b0;
      r_rx_ovf    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_tx_ovf    <= w_tx_drop | (r_tx_ovf & ~w_st_clr);
      r_rx_ovf    <= w_rx_drop | (r_rx_ovf & ~w_st_clr);
      r_frame_err <= w_rx_ferr | (r_frame_err & ~w_st_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= '0;
    end else if (w_hit && w_rd) begin
      case (w_ofs)
        OFS_RXDATA: r_dout <= w_rx_empty ? '0 : {1'b1, 23'b0, w_rx_rdata};
        OFS_STATUS: r_dout <= w_status;
        default:    r_dout <= '0;
      endcase
    end
  end

  assign dout = r_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= IDLE;
      r_tx_baud  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_txd      <= 1'b1;
    end else begin
      case (r_tx_state)
        IDLE: begin
          if (!w_tx_empty) begin
            r_tx_shift <= w_tx_rdata;
            r_txd      <= 1'b0;
            r_tx_baud  <= '0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud  <= '0;
            r_tx_bit   <= '0;
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_state <= DATA;
          end else begin
            r_tx_baud <= r_tx_baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud <= '0;
            r_tx_bit  <= r_tx_bit + 3'd1;
            if (r_tx_bit == 3'd7) begin
              r_txd      <= 1'b1;
              r_tx_state <= STOP;
            end else begin
              r_txd      <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_baud <= r_tx_baud + BAUD_ONE;
          end
        end
        STOP: begin
          if (r_tx_baud == BAUD_LAST) begin
            r_tx_baud  <= '0;
            r_tx_state <= IDLE;
          end else begin
            r_tx_baud <= r_tx_baud + BAUD_ONE;
          end
        end
      endcase
    end
  end

  assign txd = r_txd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_state <= IDLE;
      r_rx_baud  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
    end else begin
      r_rx_s1 <= rxd;
      r_rx_s2 <= r_rx_s1;
      case (r_rx_state)
        IDLE: begin
          if (!r_rx_s2) begin
            r_rx_baud  <= '0;
            r_rx_state <= START;
          end
        end
        START: begin
          // Half-bit check realigns all later samples to bit centres.
          if (r_rx_baud == BAUD_HALF) begin
            r_rx_baud  <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= r_rx_s2 ? IDLE : DATA;
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_ONE;
          end
        end
        DATA: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= STOP;
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_ONE;
          end
        end
        STOP: begin
          if (r_rx_baud == BAUD_LAST) begin
            r_rx_baud  <= '0;
            r_rx_state <= IDLE;
          end else begin
            r_rx_baud <= r_rx_baud + BAUD_ONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Scoreboard bench for uart_mmio: a transaction-level model predicts read
// data and transmitted bytes; monitors compare against dout and the txd line.
module tb_uart_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] A_RX = BASE + 32'h0;
  localparam logic [31:0] A_TX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] din;
  logic [3:0]  we;
  logic        re;
  logic [31:0] dout;
  logic        txd;
  logic        rxd;

  uart_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .din          (din),
    .write_enable (we),
    .read_enable  (re),
    .dout         (dout),
    .txd          (txd),
    .rxd          (rxd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: FIFO contents as queues, the transmitter as a
  // "busy until cycle" stamp (one frame = start + 8 data + stop bits, plus
  // the idle cycle in which the next byte is taken).
  longint      cyc = 0;
  longint      tx_free = 0;
  logic [7:0]  tx_fifo[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rxq[$];
  logic [31:0] rd_exp[$];
  bit          m_tx_ovf, m_rx_ovf, m_ferr;
  logic [31:0] m_dout = '0;

  always @(posedge clk) begin
    bit          hit, popped, clr;
    logic [3:0]  ofs;
    logic [31:0] st;
    if (rst) begin
      tx_fifo.delete(); tx_exp.delete(); rxq.delete();
      m_tx_ovf = 0; m_rx_ovf = 0; m_ferr = 0; m_dout = '0;
      tx_free = cyc;
    end else begin
      hit = (addr[31:4] == BASE[31:4]);
      ofs = addr[3:0];
      st = {26'd0, m_tx_ovf, m_ferr, m_rx_ovf,
            (tx_fifo.size() == 0 && cyc >= tx_free), (tx_fifo.size() == DEPTH), (rxq.size() != 0)};
      clr = 0;
      if (re) begin
        if (we == 4'd0 && hit) begin
          if (ofs == 4'h0) begin
            if (rxq.size() != 0) m_dout = {1'b1, 23'd0, rxq.pop_front()};
            else m_dout = '0;
          end else if (ofs == 4'hC) begin
            m_dout = st;
            clr = 1;
          end else begin
            m_dout = '0;
          end
        end
        rd_exp.push_back(m_dout);
      end
      if (clr) begin m_tx_ovf = 0; m_rx_ovf = 0; m_ferr = 0; end
      popped = 0;
      if (tx_fifo.size() != 0 && cyc >= tx_free) begin
        tx_exp.push_back(tx_fifo.pop_front());
        tx_free = cyc + 1 + 10 * CPB;
        popped = 1;
      end
      if (we != 4'd0 && hit && ofs == 4'h4) begin
        if (tx_fifo.size() == DEPTH) m_tx_ovf = 1;
        else tx_fifo.push_back(din[7:0]);
      end
    end
    cyc++;
  end

  // Read-response monitor.
  always @(negedge clk) begin
    if (rd_exp.size() != 0) check("rd_dout", dout, rd_exp.pop_front());
  end

  // TX line monitor: decodes frames at bit centres and pops expected bytes.
  int         txm_cnt = 0;
  bit         txm_on = 0;
  logic [7:0] txm_byte = '0;
  logic       txm_prev = 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      txm_on = 0;
    end else if (!txm_on) begin
      if (txd === 1'b0 && txm_prev === 1'b1) begin
        txm_on = 1;
        txm_cnt = 0;
      end
    end else begin
      txm_cnt++;
      if (txm_cnt == CPB / 2) begin
        check("tx_start_bit", 32'(txd), 32'd0);
      end else if (txm_cnt == 9 * CPB + CPB / 2) begin
        check("tx_stop_bit", 32'(txd), 32'd1);
        check("tx_frame_expected", 32'(tx_exp.size() != 0), 32'd1);
        if (tx_exp.size() != 0) check("tx_byte", 32'(txm_byte), 32'(tx_exp.pop_front()));
        txm_on = 0;
      end else if (txm_cnt > CPB && ((txm_cnt - CPB / 2) % CPB) == 0) begin
        txm_byte = {txd, txm_byte[7:1]};
      end
    end
    txm_prev = txd;
  end

  task automatic bus(input logic [3:0] w, input logic r, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    we = w; re = r; addr = a; din = d;
  endtask

  task automatic idle(input int n);
    repeat (n) bus(4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] a);
    bus(4'd0, 1'b1, a, 32'd0);
    bus(4'd0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    bus(4'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (CPB) begin @(posedge clk); #1; end
    end
    rxd = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    if (!stop_ok) m_ferr = 1;
    else if (rxq.size() == DEPTH) m_rx_ovf = 1;
    else rxq.push_back(b);
  endtask

  task automatic wait_tx_drain(input int limit);
    int n;
    n = 0;
    while ((tx_fifo.size() != 0 || tx_exp.size() != 0 || cyc <= tx_free) && n < limit) begin
      idle(1);
      n++;
    end
    check("tx_drain_in_time", 32'(n < limit), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int unsigned k;
    int          low_cnt;
    logic [31:0] a;
    rst = 1'b1; we = '0; re = 1'b0; addr = '0; din = '0; rxd = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_dout", dout, 32'd0);
    rd(A_ST);

    // Single TX byte with exact start latency.
    bus(4'b0001, 1'b0, A_TX, 32'h0000_00A5);
    bus(4'd0, 1'b0, 32'd0, 32'd0);
    @(negedge clk); check("tx_not_early", 32'(txd), 32'd1);
    @(negedge clk); check("tx_start_latency", 32'(txd), 32'd0);
    idle(45);
    rd(A_ST);

    // RX byte, pop, then empty read.
    rx_frame(8'h3C, 1'b1);
    rd(A_ST);
    rd(A_RX);
    rd(A_RX);

    // TX overflow with back-to-back writes, then clear-on-read.
    for (int i = 0; i < 18; i++) bus(4'b0001, 1'b0, A_TX, $urandom);
    rd(A_ST);
    rd(A_ST);
    wait_tx_drain(2000);

    // Framing errors, alone and with a byte already queued.
    rx_frame(8'($urandom), 1'b0);
    rd(A_ST);
    rx_frame(8'($urandom), 1'b1);
    rx_frame(8'($urandom), 1'b0);
    rd(A_ST);
    rd(A_RX);
    rd(A_RX);

    // RX overflow on the seventeenth frame.
    for (int i = 0; i < DEPTH + 1; i++) rx_frame(8'($urandom), 1'b1);
    rd(A_ST);
    rd(A_ST);
    for (int i = 0; i < DEPTH + 1; i++) rd(A_RX);

    // Randomised bus traffic interleaved with RX frames.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: bus(4'($urandom_range(1, 15)), 1'b0, A_TX, $urandom);
        3: begin
          a = BASE | (32'($urandom_range(0, 3)) << 2);
          if (a == A_TX) a = A_ST;
          bus(4'($urandom_range(1, 15)), 1'b0, a, $urandom);
        end
        4, 5: bus(4'd0, 1'b1, BASE | 32'($urandom_range(0, 15)), 32'd0);
        6: begin
          a = $urandom;
          if (a[31:4] == BASE[31:4]) a[31] = ~a[31];
          bus(4'(($urandom_range(0, 1)) * 4'hF), 1'b1, a, $urandom);
        end
        7: bus(4'b0001, 1'b1, ($urandom_range(0, 1) != 0) ? A_ST : A_TX, $urandom);
        default: idle(1);
      endcase
      if (i % 50 == 49) begin
        rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
        rd(A_ST);
        rd(A_RX);
      end
    end
    idle(1);
    rd(A_ST);
    wait_tx_drain(2000);

    // Reset in the middle of a TX frame's data bits.
    bus(4'b0001, 1'b0, A_TX, 32'h0000_0055);
    bus(4'b0001, 1'b0, A_TX, 32'h0000_00F0);
    idle(15);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check("rst_abort_txd", 32'(txd), 32'd1);
    check("rst_abort_dout", dout, 32'd0);
    low_cnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) low_cnt++;
    end
    check("tx_silent_after_rst", 32'(low_cnt), 32'd0);
    rd(A_ST);
    idle(3);
    check("rd_responses_drained", 32'(rd_exp.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
